modular_multiplier: RTL and testbench

MODULAR_MULTIPLIER -- requirements
Module: modular_multiplier

---
 rtl/ecc_pkg.sv | 20 ++
 rtl/mod_reduce_step.sv | 28 ++
 rtl/modular_multiplier.sv | 95 +++++++++
 tb/tb_modular_multiplier.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ============================================================================
// Module      : ecc_pkg
// Description : Shared width constant and state encoding for field arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_pkg;

    localparam int ECC_N = 231;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } ecc_state_t;

endpackage

`default_nettype wire

// File: rtl/mod_reduce_step.sv
// ============================================================================
// Module      : mod_reduce_step
// Description : Combinational reduction of a value below 3p into [0, p).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_reduce_step #(
    parameter int n = 231
) (
    input  logic [n+1:0] x,
    input  logic [n-1:0] p,
    output logic [n-1:0] y
);

    logic [n+1:0] w_p_ext;
    logic [n+1:0] w_s1;
    logic         w_ge2;

    assign w_p_ext = {2'b00, p};
    assign w_s1    = (x >= w_p_ext) ? (x - w_p_ext) : x;
    assign w_ge2   = (w_s1 >= w_p_ext);
    // Final value is below p < 2^n, so the low n bits of the difference suffice.
    assign y       = w_ge2 ? (w_s1[n-1:0] - p) : w_s1[n-1:0];

endmodule

`default_nettype wire

// File: rtl/modular_multiplier.sv
// ============================================================================
// Module      : modular_multiplier
// Description : Bit-serial MSB-first interleaved modular multiplier, R = A*B mod p.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modular_multiplier
    import ecc_pkg::*;
#(
    parameter int n = ECC_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] p,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] R,
    output logic         busy,
    output logic         result_ready
);

    // Extra MSB flags the wrap past bit 0, giving one trailing cycle to publish R.
    localparam int c_CNT_W = $clog2(n) + 1;

    ecc_state_t           r_state;
    logic [n+1:0]         r_acc;
    logic [n-1:0]         r_p;
    logic [n-1:0]         r_a;
    logic [n-1:0]         r_b;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [n+1:0]         w_dbl;
    logic [n+1:0]         w_sum;
    logic [n-1:0]         w_red;

    assign w_dbl = r_acc << 1;
    assign w_sum = w_dbl + (r_b[n-1] ? {2'b00, r_a} : {(n+2){1'b0}});

    mod_reduce_step #(
        .n (n)
    ) u_reduce (
        .x (w_sum),
        .p (r_p),
        .y (w_red)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_p          <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_cnt        <= '0;
            R            <= '0;
            busy         <= 1'b0;
            result_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_p          <= p;
                        r_a          <= A;
                        r_b          <= B;
                        r_acc        <= '0;
                        r_cnt        <= c_CNT_W'(n - 1);
                        result_ready <= 1'b0;
                        busy         <= 1'b1;
                        r_state      <= CALC;
                    end
                end
                CALC: begin
                    if (r_cnt[c_CNT_W-1]) begin
                        R            <= r_acc[n-1:0];
                        result_ready <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= DONE;
                    end else begin
                        r_acc <= {2'b00, w_red};
                        r_b   <= r_b << 1;
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_modular_multiplier.sv
// ============================================================================
// Module      : tb_modular_multiplier
// Description : Directed self-checking bench for n=8 plus a short n=231 regression.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modular_multiplier;

    logic         clk;
    logic         reset;

    logic         start8;
    logic [7:0]   p8, a8, b8, r8;
    logic         busy8, rr8;

    logic         start_w;
    logic [230:0] p_w, a_w, b_w, r_w;
    logic         busy_w, rr_w;

    int total;
    int bad;
    int edges;

    modular_multiplier #(.n(8)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (start8),
        .p            (p8),
        .A            (a8),
        .B            (b8),
        .R            (r8),
        .busy         (busy8),
        .result_ready (rr8)
    );

    modular_multiplier #(.n(231)) u_dut231 (
        .clk          (clk),
        .reset        (reset),
        .start        (start_w),
        .p            (p_w),
        .A            (a_w),
        .B            (b_w),
        .R            (r_w),
        .busy         (busy_w),
        .result_ready (rr_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [230:0] obs, input logic [230:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a start, then count edges to result_ready and check the outcome.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_r);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b;
        check({tag, "_busy_on_start"}, {230'd0, busy8}, 231'd1);
        check({tag, "_rr_drop"}, {230'd0, rr8}, 231'd0);
        edges = 0;
        while (!rr8 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 231'(edges), 231'd9);
        check({tag, "_R"}, {223'd0, r8}, {223'd0, exp_r});
        check({tag, "_busy_done"}, {230'd0, busy8}, 231'd0);
    endtask

    function automatic logic [230:0] rand231(input logic [230:0] modulus);
        logic [255:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return 231'(v % {25'd0, modulus});
    endfunction

    function automatic logic [230:0] mulmod231(input logic [230:0] a, input logic [230:0] b,
                                               input logic [230:0] m);
        logic [461:0] prod;
        prod = {231'd0, a} * {231'd0, b};
        return 231'(prod % {231'd0, m});
    endfunction

    initial begin
        logic [230:0] wa, wb, wexp;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        start8 = 1'b0; p8 = 8'd251; a8 = '0; b8 = '0;
        start_w = 1'b0; p_w = {231{1'b1}}; a_w = '0; b_w = '0;

        #1;
        check("reset_R", {223'd0, r8}, 231'd0);
        check("reset_busy", {230'd0, busy8}, 231'd0);
        check("reset_rr", {230'd0, rr8}, 231'd0);

        // start held while reset is low must be ignored
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
        @(posedge clk); #1;
        check("start_in_reset", {230'd0, busy8}, 231'd0);
        @(negedge clk);
        start8 = 1'b0;
        reset = 1'b1;

        run8("mul_3x5", 8'd3, 8'd5, 8'd15);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold_R", {223'd0, r8}, 231'd15);
        check("done_hold_rr", {230'd0, rr8}, 231'd1);

        run8("mul_250x250", 8'd250, 8'd250, 8'd1);
        run8("mul_2x126", 8'd2, 8'd126, 8'd1);
        run8("mul_0x200", 8'd0, 8'd200, 8'd0);
        run8("mul_200x0", 8'd200, 8'd0, 8'd0);

        // start during CALC is ignored, inputs may change freely
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 0;
        repeat (3) begin @(posedge clk); #1; edges++; end
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
        @(posedge clk); #1;
        edges++;
        start8 = 1'b0; a8 = 8'd55; b8 = 8'd77; p8 = 8'd13;
        check("ignore_busy", {230'd0, busy8}, 231'd1);
        while (!rr8 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check("ignore_latency", 231'(edges), 231'd9);
        check("ignore_R", {223'd0, r8}, 231'd63);
        p8 = 8'd251;

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_R", {223'd0, r8}, 231'd0);
        check("midreset_busy", {230'd0, busy8}, 231'd0);
        check("midreset_rr", {230'd0, rr8}, 231'd0);
        @(negedge clk);
        reset = 1'b1;
        run8("mul_10x30", 8'd10, 8'd30, 8'd49);

        // wide regression: boundary case first, then back-to-back restarts from DONE
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                wa = p_w - 231'd1;
                wb = p_w - 231'd1;
            end else begin
                wa = rand231(p_w);
                wb = rand231(p_w);
            end
            wexp = mulmod231(wa, wb, p_w);
            @(negedge clk);
            a_w = wa; b_w = wb; start_w = 1'b1;
            @(posedge clk); #1;
            start_w = 1'b0;
            a_w = ~wa; b_w = ~wb;
            check("w231_rr_drop", {230'd0, rr_w}, 231'd0);
            edges = 0;
            while (!rr_w && edges < 300) begin
                @(posedge clk); #1;
                edges++;
            end
            check("w231_latency", 231'(edges), 231'd232);
            check("w231_R", r_w, wexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
